cache_req_arbiter: RTL and testbench

- Two-port front end that shares one cache_system_2level instance between two requesters, e.g. instruction fetch (port 0) and data load (port 1).
- Accepts valid/ready read requests and arbitrates round-robin when both ports request.
- Sequences the cache read pulse, captures the data and hit level the cache returns, and sends a one-cycle response to the granted port.
- Keeps saturating L1-hit, L2-hit and memory-fill statistics counters for the simulator's reporting.

---
 rtl/cache_req_arbiter_if.sv | 43 ++++
 rtl/cache_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_arbiter_if.sv
// Request/response and cache-side bus for the two-port cache request arbiter.
interface cache_req_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11
) ();
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  resp0_valid;
  logic [DATA_WIDTH-1:0] resp0_data;
  logic [1:0]            resp0_level;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req1_ready;
  logic                  resp1_valid;
  logic [DATA_WIDTH-1:0] resp1_data;
  logic [1:0]            resp1_level;

  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_read;
  logic [DATA_WIDTH-1:0] cache_read_data;
  logic                  cache_l1_hit;
  logic                  cache_l2_hit;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    input  cache_read_data, cache_l1_hit, cache_l2_hit,
    output req0_ready, resp0_valid, resp0_data, resp0_level,
    output req1_ready, resp1_valid, resp1_data, resp1_level,
    output cache_addr, cache_read
  );

  // Requesters plus the shared cache.
  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    output cache_read_data, cache_l1_hit, cache_l2_hit,
    input  req0_ready, resp0_valid, resp0_data, resp0_level,
    input  req1_ready, resp1_valid, resp1_data, resp1_level,
    input  cache_addr, cache_read
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// Two-port round-robin front end sharing one two-level cache.
// Each transaction: accept (IDLE) -> issue read pulse (ISSUE) -> capture
// cache outputs (WAIT) -> one-cycle response to the owning port.
module cache_req_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_req_arbiter_if.slave   bus,
  input  logic                 stat_clear_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] stat_l1_hits_o,
  output logic [CNT_WIDTH-1:0] stat_l2_hits_o,
  output logic [CNT_WIDTH-1:0] stat_mem_fills_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic                  cache_read_q;
  logic                  resp0_valid_q, resp1_valid_q;
  logic [DATA_WIDTH-1:0] resp0_data_q, resp1_data_q;
  logic [1:0]            resp0_level_q, resp1_level_q;
  logic [CNT_WIDTH-1:0]  l1_cnt_q, l2_cnt_q, mem_cnt_q;

  logic                  grant0_s, grant1_s, accept_s, wait_s;
  logic [1:0]            level_s;

  // Source encoding: L1 wins over L2; neither means a memory fill.
  function automatic logic [1:0] hit_level(input logic l1, input logic l2);
    if (l1)      return 2'b01;
    else if (l2) return 2'b10;
    else         return 2'b11;
  endfunction

  // Increment that sticks at all ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign accept_s = grant0_s | grant1_s;
  assign wait_s   = (state_q == ST_WAIT);
  assign level_s  = hit_level(bus.cache_l1_hit, bus.cache_l2_hit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one fixed three-cycle pass per accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_s) state_d = ST_ISSUE; else state_d = ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: grant only in IDLE; rr_q breaks ties when both request.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    busy_o   = (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_s = ~rr_q;
        grant1_s = rr_q;
      end else begin
        grant0_s = bus.req0_valid;
        grant1_s = bus.req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Cache request side: latch address/owner on accept, one-cycle read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_addr_q <= {ADDR_WIDTH{1'b0}};
      cache_read_q <= 1'b0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
    end else if (accept_s) begin
      cache_addr_q <= grant1_s ? bus.req1_addr : bus.req0_addr;
      cache_read_q <= 1'b1;
      owner_q      <= grant1_s;
      rr_q         <= ~grant1_s;
    end else if (state_q == ST_ISSUE) begin
      cache_read_q <= 1'b0;
    end else begin
      cache_read_q <= cache_read_q;
    end
  end

  // Response capture: only the owner's registers change; data/level persist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= {DATA_WIDTH{1'b0}};
      resp1_data_q  <= {DATA_WIDTH{1'b0}};
      resp0_level_q <= 2'b00;
      resp1_level_q <= 2'b00;
    end else begin
      resp0_valid_q <= wait_s && !owner_q;
      resp1_valid_q <= wait_s && owner_q;
      if (wait_s && !owner_q) begin
        resp0_data_q  <= bus.cache_read_data;
        resp0_level_q <= level_s;
      end
      if (wait_s && owner_q) begin
        resp1_data_q  <= bus.cache_read_data;
        resp1_level_q <= level_s;
      end
    end
  end

  // Statistics: clear dominates any same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_cnt_q  <= {CNT_WIDTH{1'b0}};
      l2_cnt_q  <= {CNT_WIDTH{1'b0}};
      mem_cnt_q <= {CNT_WIDTH{1'b0}};
    end else if (stat_clear_i) begin
      l1_cnt_q  <= {CNT_WIDTH{1'b0}};
      l2_cnt_q  <= {CNT_WIDTH{1'b0}};
      mem_cnt_q <= {CNT_WIDTH{1'b0}};
    end else if (wait_s) begin
      if (level_s == 2'b01) l1_cnt_q  <= sat_inc(l1_cnt_q);
      if (level_s == 2'b10) l2_cnt_q  <= sat_inc(l2_cnt_q);
      if (level_s == 2'b11) mem_cnt_q <= sat_inc(mem_cnt_q);
    end
  end

  assign bus.req0_ready     = grant0_s;
  assign bus.req1_ready     = grant1_s;
  assign bus.cache_addr     = cache_addr_q;
  assign bus.cache_read     = cache_read_q;
  assign bus.resp0_valid    = resp0_valid_q;
  assign bus.resp1_valid    = resp1_valid_q;
  assign bus.resp0_data     = resp0_data_q;
  assign bus.resp1_data     = resp1_data_q;
  assign bus.resp0_level    = resp0_level_q;
  assign bus.resp1_level    = resp1_level_q;
  assign stat_l1_hits_o     = l1_cnt_q;
  assign stat_l2_hits_o     = l2_cnt_q;
  assign stat_mem_fills_o   = mem_cnt_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter. Counters are built 2 bits wide so
// saturation is reachable. The cache stand-in returns addr ^ 0x3E3 and the
// hit flags chosen by each test.
module tb_cache_req_arbiter;
  localparam int AW = 11;
  localparam int DW = 11;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          stat_clear;
  logic          busy;
  logic [CW-1:0] l1c, l2c, mc;
  logic          hit_l1, hit_l2;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            r0_pulses = 0;
  int            r1_pulses = 0;

  cache_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cache_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .stat_clear_i     (stat_clear),
    .busy_o           (busy),
    .stat_l1_hits_o   (l1c),
    .stat_l2_hits_o   (l2c),
    .stat_mem_fills_o (mc)
  );

  always #5 clk = ~clk;

  assign bus.cache_read_data = bus.cache_addr ^ 11'h3E3;
  assign bus.cache_l1_hit    = hit_l1;
  assign bus.cache_l2_hit    = hit_l2;

  always @(negedge clk) begin
    if (bus.resp0_valid) r0_pulses <= r0_pulses + 1;
    if (bus.resp1_valid) r1_pulses <= r1_pulses + 1;
  end

  // Fixed-timing single request from IDLE; returns on the negedge where the
  // response is visible (3 cycles after the accepting edge).
  task automatic run_txn(input logic port, input logic [AW-1:0] addr);
    @(negedge clk);
    if (port) begin bus.req1_valid = 1'b1; bus.req1_addr = addr; end
    else      begin bus.req0_valid = 1'b1; bus.req0_addr = addr; end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bus.cache_read !== 1'b0 || bus.cache_addr !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b read=%b addr=%h expected 0 0 000", busy, bus.cache_read, bus.cache_addr);
    end
    tests_run++;
    if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0 || bus.resp0_data !== 11'h000 ||
        bus.resp1_level !== 2'b00 || l1c !== 2'd0 || l2c !== 2'd0 || mc !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_resp: v0=%b v1=%b d0=%h lv1=%b cnt=%0d/%0d/%0d expected all 0",
               bus.resp0_valid, bus.resp1_valid, bus.resp0_data, bus.resp1_level, l1c, l2c, mc);
    end
    rst = 1'b0;
  endtask

  task automatic test_mem_fill;
    hit_l1 = 1'b0; hit_l2 = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 11'h010;
    #1;
    tests_run++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_ready: rdy0=%b rdy1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    tests_run++;
    if (bus.cache_read !== 1'b1 || bus.cache_addr !== 11'h010 || busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL issue: read=%b addr=%h busy=%b rdy0=%b expected 1 010 1 0",
               bus.cache_read, bus.cache_addr, busy, bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.cache_read !== 1'b0 || bus.resp0_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait: read=%b v0=%b busy=%b expected 0 0 1", bus.cache_read, bus.resp0_valid, busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.resp0_valid !== 1'b1 || bus.resp0_data !== 11'h3F3 || bus.resp0_level !== 2'b11 ||
        mc !== 2'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_resp: v0=%b d0=%h lv=%b fills=%0d busy=%b expected 1 3f3 11 1 0",
               bus.resp0_valid, bus.resp0_data, bus.resp0_level, mc, busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.resp0_valid !== 1'b0 || bus.resp0_data !== 11'h3F3) begin
      tests_failed++;
      $display("FAIL resp_hold: v0=%b d0=%h expected 0 3f3", bus.resp0_valid, bus.resp0_data);
    end
  endtask

  task automatic test_levels;
    int p1;
    p1 = r1_pulses;
    hit_l1 = 1'b1; hit_l2 = 1'b0;
    run_txn(1'b0, 11'h010);
    tests_run++;
    if (bus.resp0_valid !== 1'b1 || bus.resp0_data !== 11'h3F3 || bus.resp0_level !== 2'b01 || l1c !== 2'd1) begin
      tests_failed++;
      $display("FAIL l1_resp: v0=%b d0=%h lv=%b l1=%0d expected 1 3f3 01 1",
               bus.resp0_valid, bus.resp0_data, bus.resp0_level, l1c);
    end
    tests_run++;
    if (r1_pulses !== p1 || bus.resp1_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL resp1_quiet: pulses=%0d expected %0d", r1_pulses, p1);
    end
    hit_l1 = 1'b0; hit_l2 = 1'b1;
    run_txn(1'b1, 11'h030);
    tests_run++;
    if (bus.resp1_valid !== 1'b1 || bus.resp1_data !== 11'h3D3 || bus.resp1_level !== 2'b10 || l2c !== 2'd1) begin
      tests_failed++;
      $display("FAIL l2_resp: v1=%b d1=%h lv=%b l2=%0d expected 1 3d3 10 1",
               bus.resp1_valid, bus.resp1_data, bus.resp1_level, l2c);
    end
    tests_run++;
    if (bus.resp0_valid !== 1'b0 || bus.resp0_data !== 11'h3F3 || bus.resp0_level !== 2'b01) begin
      tests_failed++;
      $display("FAIL non_owner: v0=%b d0=%h lv0=%b expected 0 3f3 01",
               bus.resp0_valid, bus.resp0_data, bus.resp0_level);
    end
  endtask

  task automatic test_round_robin;
    int acc0, acc1, ngr, first, prev, alt_err, overlap, crc, cr_err, r0, r1, derr;
    logic prev_cr, g;
    acc0 = 0; acc1 = 0; ngr = 0; first = -1; prev = -1; alt_err = 0; overlap = 0;
    crc = 0; cr_err = 0; r0 = 0; r1 = 0; derr = 0; prev_cr = 1'b0;
    hit_l1 = 1'b1; hit_l2 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.req0_valid = (acc0 < 4); bus.req0_addr = 11'h020;
      bus.req1_valid = (acc1 < 4); bus.req1_addr = 11'h030;
      #1;
      if (bus.req0_ready && bus.req1_ready) overlap++;
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        if (ngr == 0) first = int'(g);
        else if (int'(g) == prev) alt_err++;
        prev = int'(g);
        ngr++;
        if (g) acc1++; else acc0++;
      end
      if (bus.cache_read) begin
        crc++;
        if (prev_cr) cr_err++;
      end
      prev_cr = bus.cache_read;
      if (bus.resp0_valid) begin
        r0++;
        if (bus.resp0_data !== 11'h3C3 || bus.resp0_level !== 2'b01) derr++;
      end
      if (bus.resp1_valid) begin
        r1++;
        if (bus.resp1_data !== 11'h3D3 || bus.resp1_level !== 2'b01) derr++;
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tests_run++;
    if (first !== 0 || alt_err !== 0 || ngr !== 8 || overlap !== 0) begin
      tests_failed++;
      $display("FAIL rr_grants: first=%0d alt_err=%0d grants=%0d overlap=%0d expected 0 0 8 0",
               first, alt_err, ngr, overlap);
    end
    tests_run++;
    if (r0 !== 4 || r1 !== 4 || derr !== 0) begin
      tests_failed++;
      $display("FAIL rr_resps: r0=%0d r1=%0d data_err=%0d expected 4 4 0", r0, r1, derr);
    end
    tests_run++;
    if (crc !== 8 || cr_err !== 0 || l1c !== 2'd3) begin
      tests_failed++;
      $display("FAIL rr_reads: reads=%0d back_to_back=%0d l1=%0d expected 8 0 3", crc, cr_err, l1c);
    end
  endtask

  task automatic test_reset_mid;
    int p0, p1;
    hit_l1 = 1'b1; hit_l2 = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 11'h050;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    tests_run++;
    if (bus.cache_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_abort: read=%b expected 1", bus.cache_read);
    end
    p0 = r0_pulses; p1 = r1_pulses;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.cache_read !== 1'b0 || bus.cache_addr !== 11'h000 || busy !== 1'b0 ||
        bus.resp0_data !== 11'h000 || bus.resp1_data !== 11'h000 || bus.resp0_level !== 2'b00 ||
        l1c !== 2'd0 || l2c !== 2'd0 || mc !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: read=%b addr=%h busy=%b d0=%h d1=%h lv0=%b cnt=%0d/%0d/%0d expected all 0",
               bus.cache_read, bus.cache_addr, busy, bus.resp0_data, bus.resp1_data, bus.resp0_level, l1c, l2c, mc);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (r0_pulses !== p0 || r1_pulses !== p1) begin
      tests_failed++;
      $display("FAIL abandoned: pulses=%0d/%0d expected %0d/%0d", r0_pulses, r1_pulses, p0, p1);
    end
    bus.req0_valid = 1'b1; bus.req0_addr = 11'h020;
    bus.req1_valid = 1'b1; bus.req1_addr = 11'h030;
    #1;
    tests_run++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_restart: rdy0=%b rdy1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.resp0_valid !== 1'b1 || bus.resp0_data !== 11'h3C3 || l1c !== 2'd1) begin
      tests_failed++;
      $display("FAIL post_reset_txn: v0=%b d0=%h l1=%0d expected 1 3c3 1", bus.resp0_valid, bus.resp0_data, l1c);
    end
  endtask

  task automatic test_saturation;
    logic [CW-1:0] exp;
    hit_l1 = 1'b1; hit_l2 = 1'b0;
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    tests_run++;
    if (l1c !== 2'd0) begin
      tests_failed++;
      $display("FAIL clear_idle: l1=%0d expected 0", l1c);
    end
    for (int i = 1; i <= 5; i++) begin
      run_txn(1'b0, 11'h010);
      exp = (i > 3) ? 2'd3 : CW'(i);
      tests_run++;
      if (l1c !== exp) begin
        tests_failed++;
        $display("FAIL sat_%0d: l1=%0d expected %0d", i, l1c, exp);
      end
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 11'h010;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    tests_run++;
    if (l1c !== 2'd0 || l2c !== 2'd0 || mc !== 2'd0 || bus.resp0_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_prio: l1=%0d l2=%0d mem=%0d v0=%b expected 0 0 0 1", l1c, l2c, mc, bus.resp0_valid);
    end
  endtask

  task automatic test_back_to_back;
    hit_l1 = 1'b0; hit_l2 = 1'b1;
    run_txn(1'b0, 11'h011);
    tests_run++;
    if (bus.resp0_valid !== 1'b1 || bus.resp0_data !== 11'h3F2 || bus.resp0_level !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_first: v0=%b d0=%h lv=%b expected 1 3f2 10", bus.resp0_valid, bus.resp0_data, bus.resp0_level);
    end
    bus.req1_valid = 1'b1; bus.req1_addr = 11'h031;
    #1;
    tests_run++;
    if (bus.req1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: rdy1=%b expected 1", bus.req1_ready);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    tests_run++;
    if (bus.cache_read !== 1'b1 || bus.cache_addr !== 11'h031 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_issue: read=%b addr=%h busy=%b expected 1 031 1", bus.cache_read, bus.cache_addr, busy);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.resp1_valid !== 1'b1 || bus.resp1_data !== 11'h3D2 || bus.resp1_level !== 2'b10 || l2c !== 2'd2) begin
      tests_failed++;
      $display("FAIL b2b_second: v1=%b d1=%h lv=%b l2=%0d expected 1 3d2 10 2",
               bus.resp1_valid, bus.resp1_data, bus.resp1_level, l2c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    stat_clear = 1'b0;
    hit_l1 = 1'b0;
    hit_l2 = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = 11'h000;
    bus.req1_valid = 1'b0; bus.req1_addr = 11'h000;
    test_reset();
    test_mem_fill();
    test_levels();
    test_round_robin();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
